// File: rtl/fifo_word_packer.sv
// Packs RATIO consecutive WIDTH-bit FIFO entries (first-word-fall-through read port)
// into one WIDTH*RATIO-bit word on a valid/ready output. Optional partial-word flush: PACKER_FLUSH_EN.
module fifo_word_packer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [WIDTH-1:0]         fifo_rdata,
  input  logic                     fifo_empty,
  output logic                     fifo_ren,
  output logic [WIDTH*RATIO-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef PACKER_FLUSH_EN
  input  logic                     flush,
  output logic [RATIO-1:0]         out_keep,
`endif
  output logic [$clog2(RATIO):0]   lane_cnt
);

  localparam int CW = $clog2(RATIO) + 1;

  // Output handshake: a word transfers on a cycle where out_valid=1 and out_ready=1;
  // out_valid and out_data are held unchanged until that transfer.
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [WIDTH*RATIO-1:0]   data_q, data_d;
  logic                     pop;
  logic                     flush_take;
`ifdef PACKER_FLUSH_EN
  logic [RATIO-1:0]         keep_q, keep_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    flush_take = 1'b0;
`ifdef PACKER_FLUSH_EN
    keep_d     = keep_q;
    flush_take = flush && (state_q == FILL) && (cnt_q != '0);
`endif
    // A flush cycle never pops, so the emitted partial word is exactly what was collected.
    pop = rstn && !fifo_empty &&
          (((state_q == FILL) && !flush_take) || ((state_q == HOLD) && out_ready));

    case (state_q)
      FILL: begin
        if (flush_take) begin
          state_d = HOLD;
`ifdef PACKER_FLUSH_EN
          for (int k = 0; k < RATIO; k++) keep_d[k] = (CW'(k) < cnt_q);
`endif
        end else if (pop) begin
          for (int k = 0; k < RATIO; k++) begin
            if (cnt_q == CW'(k)) data_d[k*WIDTH +: WIDTH] = fifo_rdata;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(RATIO - 1)) begin
            state_d = HOLD;
`ifdef PACKER_FLUSH_EN
            keep_d  = '1;
`endif
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
`ifdef PACKER_FLUSH_EN
          keep_d  = '0;
`endif
          // Zero-bubble: the entry popped during the handshake starts the next word.
          if (pop) begin
            data_d[WIDTH-1:0] = fifo_rdata;
            cnt_d             = CW'(1);
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FILL;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef PACKER_FLUSH_EN
      keep_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef PACKER_FLUSH_EN
      keep_q  <= keep_d;
`endif
    end
  end

  assign fifo_ren  = pop;
  assign out_data  = data_q;
  assign out_valid = (state_q == HOLD);
  assign lane_cnt  = cnt_q;
`ifdef PACKER_FLUSH_EN
  assign out_keep  = keep_q;
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: a queue-modelled FIFO feeds the DUT,
// a negedge monitor checks every accepted word against exp_q.
module tb_fifo_word_packer;
  localparam int WIDTH = 8;
  localparam int RATIO = 4;
  localparam int OW    = WIDTH * RATIO;
  localparam int CW    = $clog2(RATIO) + 1;

  logic              clk = 1'b0;
  logic              rstn;
  logic [WIDTH-1:0]  fifo_rdata;
  logic              fifo_empty;
  logic              fifo_ren;
  logic [OW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     lane_cnt;
`ifdef PACKER_FLUSH_EN
  logic              flush;
  logic [RATIO-1:0]  out_keep;
  logic [RATIO-1:0]  exp_keep_q[$];
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [OW-1:0]    exp_q[$];
  logic [OW-1:0]    exp_mask_q[$];
  logic [WIDTH-1:0] fifo_q[$];
  logic             starve;

  int cyc = 0;
  int ren_cnt, hs_cnt, first_ren_cyc, last_hs_cyc;
  logic prev_hold = 1'b0;
  logic [OW-1:0] held;

  always #5 clk = ~clk;

  fifo_word_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_ren   (fifo_ren),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef PACKER_FLUSH_EN
    .flush      (flush),
    .out_keep   (out_keep),
`endif
    .lane_cnt   (lane_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes exp_q on every accepted word and watches hold/pop rules.
  always @(negedge clk) begin
    logic [OW-1:0] e, m;
    cyc++;
    if (!rstn) begin
      prev_hold = 1'b0;
    end else begin
      if (fifo_empty) check("ren_while_empty", 64'(fifo_ren), 64'd0);
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(held));
      end
      if (fifo_ren) begin
        ren_cnt++;
        if (first_ren_cyc < 0) first_ren_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
        end else begin
          e = exp_q.pop_front();
          m = exp_mask_q.pop_front();
          check("word", 64'(out_data & m), 64'(e & m));
`ifdef PACKER_FLUSH_EN
          check("word_keep", 64'(out_keep), 64'(exp_keep_q.pop_front()));
`endif
        end
      end
      prev_hold = out_valid && !out_ready;
      held      = out_data;
    end
  end

  task automatic drive_fifo();
    fifo_empty = starve || (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic tick();
    logic r;
    @(posedge clk);
    r = fifo_ren;
    #1;
    if (r && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    fifo_q.push_back(d);
    drive_fifo();
  endtask

  task automatic expect_word(input logic [OW-1:0] d, input logic [OW-1:0] m,
                             input logic [RATIO-1:0] k);
    exp_q.push_back(d);
    exp_mask_q.push_back(m);
`ifdef PACKER_FLUSH_EN
    exp_keep_q.push_back(k);
`endif
  endtask

  task automatic clear_stats();
    ren_cnt = 0; hs_cnt = 0; first_ren_cyc = -1; last_hs_cyc = -1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL wait_idle_timeout: got %0d cycles, expected < %0d", n, budget);
    end
  endtask

  initial begin
    int n;
    rstn = 1'b0; out_ready = 1'b1; starve = 1'b0;
`ifdef PACKER_FLUSH_EN
    flush = 1'b0;
`endif
    clear_stats();
    // Reset with a preloaded FIFO: no pops may happen while rstn is low.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick(); tick();
    check("rst_lane_cnt", 64'(lane_cnt), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_fifo_ren", 64'(fifo_ren), 64'd0);

    // Stream one word.
    clear_stats();
    expect_word(32'h44332211, '1, 4'b1111);
    rstn = 1'b1;
    wait_idle(20);
    check("t1_ren_cnt", 64'(ren_cnt), 64'd4);
    check("t1_hs_cnt", 64'(hs_cnt), 64'd1);
    check("t1_latency", 64'(last_hs_cyc - first_ren_cyc), 64'd4);

    // Back-pressure: first word held for 10 cycles.
    clear_stats();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    expect_word(32'h04030201, '1, 4'b1111);
    expect_word(32'h08070605, '1, 4'b1111);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("t2_reach_hold", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_no_pop_in_hold", 64'(fifo_ren), 64'd0);
    end
    check("t2_held_word", 64'(out_data), 64'h04030201);
    check("t2_lane_cnt_sat", 64'(lane_cnt), 64'd4);
    out_ready = 1'b1;
    wait_idle(30);
    check("t2_hs_cnt", 64'(hs_cnt), 64'd2);

    // Zero-bubble streaming of 12 entries.
    clear_stats();
    for (int i = 0; i < 12; i++) push(8'(8'h10 + i));
    expect_word(32'h13121110, '1, 4'b1111);
    expect_word(32'h17161514, '1, 4'b1111);
    expect_word(32'h1B1A1918, '1, 4'b1111);
    wait_idle(40);
    check("t3_ren_cnt", 64'(ren_cnt), 64'd12);
    check("t3_hs_cnt", 64'(hs_cnt), 64'd3);
    check("t3_cycles", 64'(last_hs_cyc - first_ren_cyc), 64'd12);

    // Starved FIFO: one entry every 3 cycles.
    clear_stats();
    expect_word(32'h8D7C6B5A, '1, 4'b1111);
    push(8'h5A); tick(); tick(); tick();
    push(8'h6B); tick(); tick(); tick();
    push(8'h7C); tick(); tick(); tick();
    push(8'h8D); tick(); tick(); tick();
    wait_idle(20);
    check("t4_hs_cnt", 64'(hs_cnt), 64'd1);
    check("t4_ren_cnt", 64'(ren_cnt), 64'd4);

    // Asynchronous reset after two pops discards the partial word.
    clear_stats();
    push(8'hC1); push(8'hC2);
    tick(); tick();
    check("t5_lane_cnt_2", 64'(lane_cnt), 64'd2);
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    #2 rstn = 1'b0;
    #1;
    check("t5_async_lane_cnt", 64'(lane_cnt), 64'd0);
    check("t5_async_out_valid", 64'(out_valid), 64'd0);
    check("t5_async_out_data", 64'(out_data), 64'd0);
    check("t5_async_fifo_ren", 64'(fifo_ren), 64'd0);
    tick(); tick();
    expect_word(32'hD4D3D2D1, '1, 4'b1111);
    rstn = 1'b1;
    wait_idle(20);
    check("t5_hs_cnt", 64'(hs_cnt), 64'd1);

`ifdef PACKER_FLUSH_EN
    // Flush of a partial word.
    clear_stats();
    out_ready = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    check("f_empty_flush_valid", 64'(out_valid), 64'd0);
    check("f_empty_flush_cnt", 64'(lane_cnt), 64'd0);
    push(8'hAA); push(8'hBB);
    tick(); tick();
    check("f_lane_cnt_2", 64'(lane_cnt), 64'd2);
    push(8'hCC);
    flush = 1'b1; tick(); flush = 1'b0;
    check("f_valid", 64'(out_valid), 64'd1);
    check("f_keep", 64'(out_keep), 64'b0011);
    check("f_data_lo", 64'(out_data[15:0]), 64'hBBAA);
    check("f_lane_cnt", 64'(lane_cnt), 64'd2);
    check("f_no_pop_on_flush", 64'(fifo_q.size()), 64'd1);
    expect_word(32'h0000BBAA, 32'h0000FFFF, 4'b0011);
    flush = 1'b1; tick(); flush = 1'b0;
    check("f_hold_flush_keep", 64'(out_keep), 64'b0011);
    check("f_hold_flush_valid", 64'(out_valid), 64'd1);
    fifo_q.delete();
    drive_fifo();
    out_ready = 1'b1;
    tick();
    check("f_after_valid", 64'(out_valid), 64'd0);
    check("f_after_keep", 64'(out_keep), 64'd0);
    check("f_after_cnt", 64'(lane_cnt), 64'd0);
    check("f_word_taken", 64'(exp_q.size()), 64'd0);
`endif

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of the SYNC_FIFO read port. It pops WIDTH-bit entries in first-word-fall-through fashion and packs RATIO consecutive entries into one WIDTH*RATIO-bit word.
- Presents each packed word on a valid/ready output towards the wide datapath.
- Decouples the byte-oriented FIFO from wider consumers, with full back-pressure on both sides.

Parameters:
- WIDTH, 8, entry width; must equal the FIFO WIDTH.
- RATIO, 4, entries per packed word; RATIO >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  reset, asynchronous and active-low.
- fifo_rdata  input  WIDTH  FIFO head entry; valid whenever fifo_empty=0.
- fifo_empty  input  1  FIFO empty flag.
- fifo_ren  output  1  pop strobe to the FIFO; combinational.
- out_data  output  WIDTH*RATIO  packed word; entry k occupies bits [k*WIDTH +: WIDTH], first-popped entry is k=0.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  downstream accepts the word when out_valid=1 and out_ready=1.
- lane_cnt  output  $clog2(RATIO)+1  number of entries currently held in the assembly register (0..RATIO).

Behaviour:
- Reset (rstn=0, asynchronous):
  - lane_cnt=0, out_valid=0, out_data=0, state=FILL.
  - fifo_ren=0 while rstn=0.
  - Reset mid-word discards any partial word.
- States:
  - FILL: lane_cnt < RATIO.
  - HOLD: lane_cnt == RATIO, out_valid=1.
- Pop rule: fifo_ren = !fifo_empty && (state==FILL || out_ready).
  - fifo_ren is never asserted while fifo_empty=1 (no reliance on the FIFO underflow guard).
- FILL with pop:
  - fifo_rdata is registered into lane lane_cnt, and lane_cnt increments.
  - When lane_cnt reaches RATIO, the block moves to HOLD next cycle; out_valid rises in that same cycle.
- HOLD:
  - out_data and out_valid stay stable until the handshake completes. No lane is modified while out_valid=1 and out_ready=0.
- HOLD with handshake and no pop: lane_cnt goes to 0, state goes to FILL, out_valid=0 next cycle.
- HOLD with handshake and a simultaneous pop:
  - The popped entry goes into lane 0 and lane_cnt becomes 1; state goes to FILL.
  - This gives zero bubble: sustained throughput is one word per RATIO cycles.
- Unfilled lanes keep stale data. out_data is only meaningful while out_valid=1.
- Latency: the last entry popped in cycle N appears with out_valid=1 in cycle N+1.
- Handshake: out_valid never drops without a handshake (except on reset).
- out_ready while out_valid=0 is ignored.
- fifo_empty toggling mid-word: the block simply stalls in FILL and keeps its partial word.
- lane_cnt is sized so the value RATIO is representable. Increment never wraps: lane_cnt saturates at RATIO until the handshake.

Optional Feature:
- Macro: PACKER_FLUSH_EN.
- With the macro defined, two ports are added:
  - flush (input, 1): a one-cycle request to emit a partial word.
  - out_keep (output, RATIO): per-lane valid mask.
- Flush rules:
  - flush in FILL with lane_cnt>0 forces HOLD next cycle with the lanes collected so far. No pop occurs in the flush cycle.
  - out_keep bit k = 1 for k < lane_cnt at the time of the flush. A normal full word reports out_keep = all ones.
  - flush with lane_cnt==0 is ignored.
  - flush in HOLD is ignored.
  - After the handshake, out_keep returns to 0.
- Without the macro: the flush and out_keep ports do not exist and only complete words are emitted.

Test Plan:
- Reset then stream: FIFO preloaded with 0x11,0x22,0x33,0x44, out_ready=1 -> out_data=0x44332211, out_valid for 1 cycle; fifo_ren high 4 consecutive cycles.
- Back-pressure: 8 entries 0x01..0x08, out_ready=0 for 10 cycles after the first word -> out_data=0x04030201 held stable. fifo_ren=0 while in HOLD. After release, the second word is 0x08070605.
- Zero-bubble: 12 entries continuously available, out_ready=1 -> 3 words on out_valid in exactly 12 cycles after the first pop; fifo_ren never deasserted.
- Starved FIFO: entries arrive one every 3 cycles with fifo_empty=1 in between -> fifo_ren is never high while empty; the word completes correctly after the 4th entry.
- Async reset mid-word: rstn low after 2 pops -> lane_cnt=0 and out_valid=0 immediately without a clock edge. The next 4 pops form a fresh word, with the old lanes discarded.
- PACKER_FLUSH_EN: pop 0xAA,0xBB then pulse flush -> out_valid=1, out_data[15:0]=0xBBAA, out_keep=4'b0011. After the handshake, out_keep=0 and lane_cnt=0.
